// File: rtl/field_pair_assembler.sv
// Groups a serial stream of FIELD_W-bit symbols into NUM_FIELDS-field packed words,
// first symbol in field 0; in_last flushes a partial word padded with PAD.
module field_pair_assembler #(
  parameter int                 FIELD_W    = 2,
  parameter int                 NUM_FIELDS = 2,
  parameter logic [FIELD_W-1:0] PAD        = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W-1:0]            in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W*NUM_FIELDS-1:0] out_data,
  output logic                          out_partial,
  output logic [CNT_W-1:0]              word_count
);

  localparam int WORD_W = FIELD_W * NUM_FIELDS;
  localparam int IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [WORD_W-1:0] PAD_WORD = {NUM_FIELDS{PAD}};

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_partial_q, out_partial_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              last_idx;
  logic              completing;
  logic              accept;
  logic              out_hs;
  logic [WORD_W-1:0] merged;

  assign last_idx   = (idx_q == IDX_W'(NUM_FIELDS - 1));
  assign completing = last_idx || in_last;
  // A completing beat needs the output register; everything else only touches acc_q.
  assign in_ready   = !completing || !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid_q && out_ready;

  // Fields above idx_q are still PAD in acc_q, so only field idx_q needs replacing.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (idx_q == IDX_W'(k)) merged[k*FIELD_W +: FIELD_W] = in_data;
    end
  end

  always_comb begin
    acc_d         = acc_q;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;
    cnt_d         = cnt_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      if (completing) begin
        out_data_d    = merged;
        out_partial_d = !last_idx;
        out_valid_d   = 1'b1;
        idx_d         = '0;
        acc_d         = PAD_WORD;
      end else begin
        acc_d = merged;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= PAD_WORD;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_partial_q <= out_partial_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_partial = out_partial_q;
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_field_pair_assembler.sv
// Bench for field_pair_assembler: a default instance and a PAD=2'b10 / CNT_W=2 instance
// share one stimulus stream and are compared against a queue-based word model.
module tb_field_pair_assembler;

  localparam int NF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [1:0] in_data;
  logic       in_ready, in_ready2;
  logic       out_valid, out_valid2;
  logic [3:0] out_data, out_data2;
  logic       out_partial, out_partial2;
  logic [15:0] word_count;
  logic [1:0]  word_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  field_pair_assembler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_partial(out_partial),
    .word_count(word_count)
  );

  field_pair_assembler #(.PAD(2'b10), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_partial(out_partial2),
    .word_count(word_count2)
  );

  // Reference model: symbols of the open group, and the word currently on offer.
  int   grp[$];
  bit   m_ov, m_op;
  int   m_od0, m_od2;
  int   m_cnt;
  logic rdy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int build(input int pad);
    int w = 0;
    for (int k = 0; k < NF; k++) w |= ((k < grp.size()) ? grp[k] : pad) << (2 * k);
    return w;
  endfunction

  task automatic model_reset();
    grp.delete();
    m_ov = 0; m_op = 0; m_od0 = 0; m_od2 = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), check in_ready before the edge
  // and all registered outputs just after it.
  task automatic step(input bit v, input bit [1:0] d, input bit l, input bit r);
    bit comp, rdy_m, hs, acc;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #3;
    comp  = (grp.size() == NF - 1) || l;
    rdy_m = !comp || !m_ov || r;
    rdy_seen = in_ready;
    chk("in_ready", in_ready, rdy_m);
    chk("in_ready_pad", in_ready2, rdy_m);
    hs  = m_ov && r;
    acc = v && rdy_m;
    if (hs) begin
      m_ov = 0;
      m_cnt++;
    end
    if (acc) begin
      grp.push_back(d);
      if (comp) begin
        m_od0 = build(0);
        m_od2 = build(2);
        m_op  = (grp.size() < NF);
        m_ov  = 1;
        grp.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od0);
    chk("out_partial", out_partial, m_op);
    chk("word_count", word_count, m_cnt & 16'hFFFF);
    chk("out_valid_pad", out_valid2, m_ov);
    chk("out_data_pad", out_data2, m_od2);
    chk("out_partial_pad", out_partial2, m_op);
    chk("word_count_w2", word_count2, m_cnt & 3);
  endtask

  typedef struct {
    bit       v;
    bit [1:0] d;
    bit       l;
    bit       r;
    bit       rdy;
    bit       ov;
    bit [3:0] od;
    bit       op;
    int       cnt;
  } vec_t;

  vec_t tbl[12];
  int   wrap_exp[5];

  initial begin
    tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 1'b0, 0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 1};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 1};
    tbl[4]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 1'b0, 1};
    tbl[5]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 2};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 3};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 3};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 4};
    tbl[10] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 4};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1, 5};
    wrap_exp = '{1, 2, 3, 0, 1};

    rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_data_pad", out_data2, 0);
    chk("rst_out_partial", out_partial, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors: basic pair, continuous stream, first-beat flush.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d_in_ready", i), rdy_seen, tbl[i].rdy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_out_partial", i), out_partial, tbl[i].op);
      chk($sformatf("vec%0d_word_count", i), word_count, tbl[i].cnt);
      if (i == 10) chk("flush_pad_word", out_data2, 4'b1011);
    end

    // Backpressure: completing beat stalls until the output is taken.
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 0, 0);
    chk("bp_first_word", out_data, 4'b1001);
    step(1, 2'b11, 0, 0);
    chk("bp_noncomplete_accepted", rdy_seen, 1);
    chk("bp_hold_data", out_data, 4'b1001);
    step(1, 2'b01, 0, 0);
    chk("bp_stall_ready", rdy_seen, 0);
    chk("bp_hold_data2", out_data, 4'b1001);
    chk("bp_hold_valid", out_valid, 1);
    step(1, 2'b01, 0, 1);
    chk("bp_release_ready", rdy_seen, 1);
    chk("bp_next_word", out_data, 4'b0111);
    chk("bp_next_valid", out_valid, 1);
    step(0, 2'b00, 0, 1);

    // Asynchronous reset mid-group, with a word pending.
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(1, 2'b10, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_word_count", word_count, 0);
    chk("async_out_data", out_data, 0);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 2'b01, 0, 1);
    step(1, 2'b01, 0, 1);
    chk("post_reset_word", out_data, 4'b0101);
    chk("post_reset_partial", out_partial, 0);
    step(0, 2'b00, 0, 1);

    // Narrow counter wrap on the CNT_W=2 instance.
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #2;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(i < 5, 2'b11, 1, 1);
      if (i > 0) chk($sformatf("wrap_count%0d", i), word_count2, wrap_exp[i-1]);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_pair_assembler.md
Name: field_pair_assembler

Overview:
- Upstream feeder for the packed two-field struct stage {last[1:0], first[1:0]}.
- Accepts a serial stream of FIELD_W-bit symbols over valid/ready and groups them into NUM_FIELDS-field packed words. The first symbol of a group lands in the lowest field ("first"); the final symbol lands in the highest field ("last").
- Emits each completed word through a registered valid/ready output.
- A packet-end marker flushes a partially filled word, with unfilled fields padded.

Parameters:
- FIELD_W, 2, width of one field/symbol in bits
- NUM_FIELDS, 2, fields per output word (>= 2)
- PAD, 0, value written into fields not filled when a group is flushed early (FIELD_W bits)
- CNT_W, 16, width of the emitted-word counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  symbol available
- in_ready  output  1  block accepts a symbol this cycle
- in_data  input  FIELD_W  symbol
- in_last  input  1  symbol is last of packet; forces word completion
- out_valid  output  1  out_data holds a completed word
- out_ready  input  1  consumer accepts the word this cycle
- out_data  output  FIELD_W*NUM_FIELDS  packed word; field k at bits [k*FIELD_W +: FIELD_W], field 0 = first
- out_partial  output  1  word was flushed by in_last before all fields were filled
- word_count  output  CNT_W  number of output handshakes since reset

Behaviour:
- Reset is asynchronous and active-high and takes effect immediately. It clears:
  - out_valid, out_partial: 0
  - out_data: 0
  - word_count: 0
  - accumulation register: all fields PAD
  - field index idx: 0
- Reset mid-group discards the accumulated fields; no word is emitted for them.
- An input beat is accepted when in_valid && in_ready. An output handshake occurs when out_valid && out_ready.
- A beat is "completing" if idx == NUM_FIELDS-1 or in_last == 1.
- in_ready rule:
  - in_ready = 1 when the beat would not be completing, or when the output register is free (!out_valid || out_ready).
  - in_ready may depend combinationally on in_last and out_ready. It must not depend on in_valid.
- Non-completing accepted beat: write in_data into field idx of the accumulation register; idx <= idx+1.
- Completing accepted beat, at the next edge:
  - out_data <= accumulation register with field idx replaced by in_data; fields above idx = PAD.
  - out_partial <= (idx != NUM_FIELDS-1).
  - out_valid <= 1.
  - idx <= 0; accumulation register reset to PAD.
- Latency: out_valid rises on the clock edge that accepts the completing beat, i.e. it is visible in the cycle after that beat.
- Throughput: one symbol per cycle sustained while out_ready = 1 (NUM_FIELDS cycles per word).
- Simultaneous output handshake and completing beat: the new word replaces the old one, out_valid stays 1, and there is no bubble.
- Output handshake with no completing beat: out_valid <= 0. out_data keeps its last value.
- Backpressure: while out_valid && !out_ready, out_data and out_partial hold stable. Non-completing beats are still accepted; a completing beat stalls with in_ready = 0.
- word_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- in_last with idx == NUM_FIELDS-1 produces a full word with out_partial = 0.
- in_last on the first symbol produces a word with only field 0 filled and out_partial = 1.
- in_data and in_last are ignored when in_valid = 0.

Test Plan:
- Reset, then symbols 2'b01, 2'b10 with out_ready = 1 -> out_data = 4'b1001, out_partial = 0, out_valid high for 1 cycle, word_count = 1.
- Continuous stream 01,10,11,00,10,01 with out_ready = 1 -> words 4'b1001, 4'b0011, 4'b0110 on consecutive-pair cycles, in_ready never drops, word_count = 3.
- Symbol 2'b11 with in_last = 1 as first beat -> out_data = 4'b0011, out_partial = 1. Repeat with PAD = 2'b10 -> 4'b1011.
- Backpressure: out_ready = 0 after first word 4'b1001, then feed 2'b11 (accepted), then 2'b01 (must stall, in_ready = 0) -> out_data holds 4'b1001. Raise out_ready -> next word 4'b0111 appears the cycle after the stalled beat is accepted.
- Assert rst asynchronously after one symbol (2'b10) -> out_valid = 0, word_count = 0 without a clock edge. Then 2'b01, 2'b01 -> 4'b0101 (stale field discarded).
- CNT_W = 2, emit 5 words -> word_count sequence 1,2,3,0,1.
